// File: rtl/olink_reset_sequencer.sv
// olink_reset_sequencer: staged QPLL / MMCM / GTX reset bring-up
// for the backplane optical links, with lock timeouts and retries.
module olink_reset_sequencer #(
    parameter int N_LINKS      = 2,
    parameter int RST_HOLD     = 64,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int SETTLE       = 1000,
    parameter int MAX_RETRY    = 8
) (
    input  logic               sysClk125,
    input  logic               sysClk125Rst,
    input  logic               enable,
    input  logic               force_reset,
    input  logic [N_LINKS-1:0] link_mask,
    input  logic               qpll_lock,
    input  logic               qpll_refclklost,
    input  logic               mmcm_locked,
    input  logic [N_LINKS-1:0] link_valid,
    output logic               qpll_reset,
    output logic               mmcm_reset,
    output logic [N_LINKS-1:0] gt_reset,
    output logic [3:0]         state,
    output logic               link_up,
    output logic               fail,
    output logic [3:0]         retry_count,
    output logic [7:0]         link_drops
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        QPLL_RST  = 4'd1,
        QPLL_WAIT = 4'd2,
        MMCM_RST  = 4'd3,
        MMCM_WAIT = 4'd4,
        GT_RST    = 4'd5,
        LINK_WAIT = 4'd6,
        READY     = 4'd7,
        FAIL      = 4'd8
    } state_t;

    localparam int SW = N_LINKS + 3;

    state_t cur_st;
    state_t nxt_st;

    logic [SW-1:0]      sync1;
    logic [SW-1:0]      sync2;
    logic [N_LINKS-1:0] lv_s;
    logic               ql_s;
    logic               lost_s;
    logic               ml_s;

    logic [15:0]        timer;
    logic [15:0]        settle;
    logic [15:0]        settle_n;
    logic [3:0]         retry_n;
    logic [3:0]         retry_inc;
    logic [7:0]         drops_n;
    logic               hold_done;
    logic               timeout;
    logic               links_ok;
    logic               settle_done;
    state_t             tmo_st;

    logic               qpll_rst_n;
    logic               mmcm_rst_n;
    logic [N_LINKS-1:0] gt_rst_n;
    logic               up_n;
    logic               fail_n;

    assign {lv_s, ml_s, lost_s, ql_s} = sync2;
    assign state = cur_st;

    // Two-flop synchronizers for all asynchronous status inputs
    always_ff @(posedge sysClk125) begin
        if (sysClk125Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {link_valid, mmcm_locked,
                      qpll_refclklost, qpll_lock};
            sync2 <= sync1;
        end
    end

    // Next state, counter updates and registered-output decode
    always_comb begin
        nxt_st      = cur_st;
        retry_n     = retry_count;
        drops_n     = link_drops;
        hold_done   = (timer == 16'(RST_HOLD - 1));
        timeout     = (timer == 16'(LOCK_TIMEOUT - 1));
        links_ok    = ((lv_s & link_mask) == link_mask);
        settle_n    = links_ok ? settle + 16'd1 : 16'd0;
        settle_done = links_ok && (settle == 16'(SETTLE - 1));
        retry_inc   = (retry_count == 4'hF) ? 4'hF
                                            : retry_count + 4'd1;
        tmo_st      = (int'(retry_inc) >= MAX_RETRY) ? FAIL
                                                     : QPLL_RST;

        if (!enable) begin
            nxt_st = IDLE;
        end else if (force_reset && cur_st != IDLE) begin
            nxt_st  = QPLL_RST;
            retry_n = 4'd0;
        end else begin
            unique case (cur_st)
                IDLE: begin
                    nxt_st  = QPLL_RST;
                    retry_n = 4'd0;
                end
                QPLL_RST:
                    if (hold_done) nxt_st = QPLL_WAIT;
                QPLL_WAIT:
                    if (timeout) begin
                        nxt_st  = tmo_st;
                        retry_n = retry_inc;
                    end else if (ql_s && !lost_s) begin
                        nxt_st = MMCM_RST;
                    end
                MMCM_RST:
                    if (hold_done) nxt_st = MMCM_WAIT;
                MMCM_WAIT:
                    if (timeout) begin
                        nxt_st  = tmo_st;
                        retry_n = retry_inc;
                    end else if (ml_s) begin
                        nxt_st = GT_RST;
                    end
                GT_RST:
                    if (hold_done) nxt_st = LINK_WAIT;
                LINK_WAIT:
                    if (timeout) begin
                        nxt_st  = tmo_st;
                        retry_n = retry_inc;
                    end else if (settle_done) begin
                        nxt_st = READY;
                    end
                READY:
                    if (!ql_s || lost_s || !ml_s) begin
                        nxt_st = QPLL_RST;
                    end else if (!links_ok) begin
                        nxt_st = GT_RST;
                        if (link_drops != 8'hFF)
                            drops_n = link_drops + 8'd1;
                    end
                FAIL: ;
                default: nxt_st = IDLE;
            endcase
        end

        qpll_rst_n = 1'b1;
        mmcm_rst_n = 1'b1;
        gt_rst_n   = '1;
        up_n       = 1'b0;
        fail_n     = 1'b0;
        unique case (nxt_st)
            QPLL_WAIT, MMCM_RST:
                qpll_rst_n = 1'b0;
            MMCM_WAIT, GT_RST: begin
                qpll_rst_n = 1'b0;
                mmcm_rst_n = 1'b0;
            end
            LINK_WAIT: begin
                qpll_rst_n = 1'b0;
                mmcm_rst_n = 1'b0;
                gt_rst_n   = '0;
            end
            READY: begin
                qpll_rst_n = 1'b0;
                mmcm_rst_n = 1'b0;
                gt_rst_n   = '0;
                up_n       = 1'b1;
            end
            FAIL: fail_n = 1'b1;
            default: ;
        endcase
    end

    // State, timers, counters and outputs all update together
    always_ff @(posedge sysClk125) begin
        if (sysClk125Rst) begin
            cur_st      <= IDLE;
            timer       <= '0;
            settle      <= '0;
            retry_count <= '0;
            link_drops  <= '0;
            qpll_reset  <= 1'b1;
            mmcm_reset  <= 1'b1;
            gt_reset    <= '1;
            link_up     <= 1'b0;
            fail        <= 1'b0;
        end else begin
            cur_st      <= nxt_st;
            timer       <= (nxt_st != cur_st) ? 16'd0
                                              : timer + 16'd1;
            settle      <= (nxt_st != cur_st) ? 16'd0 : settle_n;
            retry_count <= retry_n;
            link_drops  <= drops_n;
            qpll_reset  <= qpll_rst_n;
            mmcm_reset  <= mmcm_rst_n;
            gt_reset    <= gt_rst_n;
            link_up     <= up_n;
            fail        <= fail_n;
        end
    end

endmodule

// File: tb/tb_olink_reset_sequencer.sv
// tb_olink_reset_sequencer: directed scenarios plus randomized
// fault modes, checked every cycle against a behavioural model.
module tb_olink_reset_sequencer;

    localparam int NL   = 2;
    localparam int HOLD = 4;
    localparam int TMO  = 100;
    localparam int STL  = 10;
    localparam int MR   = 3;

    localparam int S_IDLE = 0;
    localparam int S_QR   = 1;
    localparam int S_QW   = 2;
    localparam int S_MR   = 3;
    localparam int S_MW   = 4;
    localparam int S_GR   = 5;
    localparam int S_LW   = 6;
    localparam int S_RDY  = 7;
    localparam int S_FAIL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fr;
    logic [NL-1:0] mask;
    logic          ql;
    logic          lost;
    logic          ml;
    logic [NL-1:0] lv;

    logic          qpll_reset;
    logic          mmcm_reset;
    logic [NL-1:0] gt_reset;
    logic [3:0]    state;
    logic          link_up;
    logic          fail;
    logic [3:0]    retry_count;
    logic [7:0]    link_drops;

    always #4 clk = ~clk;

    olink_reset_sequencer #(
        .N_LINKS     (NL),
        .RST_HOLD    (HOLD),
        .LOCK_TIMEOUT(TMO),
        .SETTLE      (STL),
        .MAX_RETRY   (MR)
    ) dut (
        .sysClk125      (clk),
        .sysClk125Rst   (rst),
        .enable         (en),
        .force_reset    (fr),
        .link_mask      (mask),
        .qpll_lock      (ql),
        .qpll_refclklost(lost),
        .mmcm_locked    (ml),
        .link_valid     (lv),
        .qpll_reset     (qpll_reset),
        .mmcm_reset     (mmcm_reset),
        .gt_reset       (gt_reset),
        .state          (state),
        .link_up        (link_up),
        .fail           (fail),
        .retry_count    (retry_count),
        .link_drops     (link_drops)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reset levels required in each state, indexed by encoding
    int qr_tab [9] = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
    int mm_tab [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    int gt_tab [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};

    int       m_st;
    int       m_t;
    int       m_run;
    int       m_retry;
    int       m_drops;
    logic [4:0] dly [2];

    task automatic model_step();
        logic       sq;
        logic       sl;
        logic       sm;
        logic [1:0] sv;
        bit         good;
        int         ns;
        if (rst) begin
            m_st = S_IDLE; m_t = 0; m_run = 0;
            m_retry = 0; m_drops = 0;
            dly[0] = '0; dly[1] = '0;
            return;
        end
        {sv, sm, sl, sq} = dly[1];
        good = ((sv & mask) == mask);
        ns = m_st;
        if (!en) begin
            ns = S_IDLE;
        end else if (fr && m_st != S_IDLE) begin
            ns = S_QR;
            m_retry = 0;
        end else begin
            case (m_st)
                S_IDLE: begin ns = S_QR; m_retry = 0; end
                S_QR: if (m_t == HOLD - 1) ns = S_QW;
                S_MR: if (m_t == HOLD - 1) ns = S_MW;
                S_GR: if (m_t == HOLD - 1) ns = S_LW;
                S_QW, S_MW, S_LW:
                    if (m_t == TMO - 1) begin
                        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                        ns = (m_retry >= MR) ? S_FAIL : S_QR;
                    end else if (m_st == S_QW) begin
                        if (sq && !sl) ns = S_MR;
                    end else if (m_st == S_MW) begin
                        if (sm) ns = S_GR;
                    end else begin
                        m_run = good ? m_run + 1 : 0;
                        if (m_run == STL) ns = S_RDY;
                    end
                S_RDY:
                    if (!sq || sl || !sm) begin
                        ns = S_QR;
                    end else if (!good) begin
                        ns = S_GR;
                        if (m_drops < 255) m_drops++;
                    end
                default: ;
            endcase
        end
        if (ns != m_st) begin
            m_t = 0;
            m_run = 0;
        end else begin
            m_t = (m_t + 1) % 65536;
        end
        m_st = ns;
        dly[1] = dly[0];
        dly[0] = {lv, ml, lost, ql};
    endtask

    task automatic check_all();
        chk("state", int'(state), m_st);
        chk("link_up", int'(link_up), int'(m_st == S_RDY));
        chk("fail", int'(fail), int'(m_st == S_FAIL));
        chk("retry", int'(retry_count), m_retry);
        chk("drops", int'(link_drops), m_drops);
        chk("qpll_rst", int'(qpll_reset), qr_tab[m_st]);
        chk("mmcm_rst", int'(mmcm_reset), mm_tab[m_st]);
        chk("gt_rst", int'(gt_reset), gt_tab[m_st] ? 3 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic wait_state(int s, int budget);
        for (int i = 0; i < budget && int'(state) != s; i++)
            tick();
    endtask

    initial begin
        int lw;
        int mode;
        rst = 1'b1; en = 1'b0; fr = 1'b0;
        mask = 2'b11; lv = 2'b11;
        ql = 1'b1; lost = 1'b0; ml = 1'b1;
        m_st = 0; m_t = 0; m_run = 0; m_retry = 0; m_drops = 0;
        dly[0] = '0; dly[1] = '0;
        @(negedge clk);
        run(3);
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_gt", int'(gt_reset), 3);
        rst = 1'b0;
        run(2);

        // nominal bring-up and settle length
        en = 1'b1;
        lw = 0;
        for (int i = 0; i < 200 && int'(state) != S_RDY; i++) begin
            tick();
            if (int'(state) == S_LW) lw++;
        end
        chk("nominal_ready", int'(state), S_RDY);
        chk("settle_len", lw, STL);

        // single-cycle drop of link 1
        lv = 2'b01;
        tick();
        lv = 2'b11;
        wait_state(S_GR, 10);
        chk("drop_gt", int'(state), S_GR);
        wait_state(S_RDY, 60);
        chk("drop_ready", int'(state), S_RDY);
        chk("drop_cnt", int'(link_drops), 1);
        chk("drop_retry", int'(retry_count), 0);

        // masked link toggles freely
        mask = 2'b01;
        lv = 2'b01;
        fr = 1'b1;
        tick();
        fr = 1'b0;
        for (int i = 0; i < 80; i++) begin
            lv = {1'($urandom_range(1)), 1'b1};
            tick();
        end
        chk("mask_ready", int'(state), S_RDY);
        chk("mask_drops", int'(link_drops), 1);

        // qpll never locks -> retries then FAIL
        ql = 1'b0;
        fr = 1'b1;
        tick();
        fr = 1'b0;
        wait_state(S_FAIL, 500);
        chk("tmo_state", int'(state), S_FAIL);
        chk("tmo_fail", int'(fail), 1);
        chk("tmo_retry", int'(retry_count), 3);
        run(20);

        // enable=0 wins over force_reset
        en = 1'b0;
        fr = 1'b1;
        tick();
        fr = 1'b0;
        chk("prio_idle", int'(state), S_IDLE);
        en = 1'b1;
        ql = 1'b1;
        tick();
        chk("prio_qrst", int'(state), S_QR);
        chk("prio_retry", int'(retry_count), 0);
        chk("prio_fail", int'(fail), 0);

        // reset in LINK_WAIT
        mask = 2'b11;
        lv = 2'b11;
        wait_state(S_LW, 200);
        chk("mid_lw", int'(state), S_LW);
        rst = 1'b1;
        tick();
        chk("mid_state", int'(state), S_IDLE);
        chk("mid_qrst", int'(qpll_reset), 1);
        chk("mid_gt", int'(gt_reset), 3);
        chk("mid_drops", int'(link_drops), 0);
        rst = 1'b0;

        // randomized fault modes
        for (int seg = 0; seg < 10; seg++) begin
            mode = int'($urandom_range(3));
            mask = 2'($urandom_range(3));
            for (int i = 0; i < 400; i++) begin
                rst  = ($urandom_range(999) == 0);
                en   = ($urandom_range(299) != 0);
                fr   = ($urandom_range(499) == 0);
                ql   = (mode == 1) ? ($urandom_range(9) == 0)
                                   : ($urandom_range(299) != 0);
                lost = ($urandom_range(399) == 0);
                ml   = (mode == 2) ? ($urandom_range(9) == 0)
                                   : ($urandom_range(299) != 0);
                lv[0] = (mode == 3) ? ($urandom_range(7) != 0)
                                    : ($urandom_range(99) != 0);
                lv[1] = (mode == 3) ? ($urandom_range(7) != 0)
                                    : ($urandom_range(99) != 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
